jtag_tap_target: RTL and testbench

JTAG TAP responder: the target end of the JTAG link driven by the bridge PHY. It oversamples TCK/TMS/TDI in the system clock domain and runs the IEEE 1149.1 16-state TAP controller. It implements instruction, BYPASS, IDCODE and one user data register, and drives TDO. It sits on the remote side of the bridge and also serves as the loopback target for bridge PHY verification.

---
 rtl/jtag_pkg.sv | 52 +++++
 rtl/jtag_tap_fsm.sv | 29 ++
 rtl/jtag_tap_target.sv | 170 +++++++++++++++++
 tb/tb_jtag_tap_target.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP controller state encoding, IEEE 1149.1 next-state table and
// the fixed Capture-IR pattern shared by the TAP responder and its FSM.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  // Low bits loaded into the IR shift register in Capture-IR; upper bits are 0.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // Standard TMS transition table, evaluated once per TCK rising edge.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller, advanced only on the one-CLK step strobe.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       step,
  input  logic       TMS,
  output tap_state_t state
);

  tap_state_t r_state;
  tap_state_t w_next;

  // State register; reset lands in Test-Logic-Reset.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= TEST_LOGIC_RESET;
    else         r_state <= w_next;
  end

  // Next state: hold unless a TCK rising strobe arrives.
  always_comb begin
    w_next = r_state;
    if (step) w_next = tap_next(r_state, TMS);
  end

  assign state = r_state;

endmodule

// File: rtl/jtag_tap_target.sv
// jtag_tap_target: JTAG TAP responder oversampled in the CLK domain.
// Registers: IR, BYPASS, user DR and (with JTAG_TAP_IDCODE_EN defined) IDCODE.
// Without JTAG_TAP_IDCODE_EN, OP_IDCODE decodes as BYPASS and the reset
// instruction is all-ones (BYPASS).
module jtag_tap_target
  import jtag_pkg::*;
#(
  parameter int                IR_LEN    = 4,
  parameter logic [31:0]       IDCODE    = 32'h4BA00477,
  parameter int                USER_LEN  = 64,
  parameter logic [IR_LEN-1:0] OP_IDCODE = 'h1,
  parameter logic [IR_LEN-1:0] OP_USER   = 'h2
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  input  logic [USER_LEN-1:0] USER_DIN,
  output logic [USER_LEN-1:0] USER_DOUT,
  output logic                USER_UPDATE
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_INSTR = OP_IDCODE;
`else
  localparam logic [IR_LEN-1:0] RST_INSTR = '1;
`endif
  localparam logic [IR_LEN-1:0] IR_CAP = IR_LEN'(IR_CAPTURE);

  logic [2:0]          r_tck_s;
  logic [1:0]          r_tms_s;
  logic [1:0]          r_tdi_s;
  logic                w_tck_r;
  logic                w_tck_f;
  tap_state_t          w_state;

  logic [IR_LEN-1:0]   r_ir;
  logic [IR_LEN-1:0]   r_ir_sr;
  logic [USER_LEN-1:0] r_user_sr;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdo_oe;
  logic [USER_LEN-1:0] r_user_dout;
  logic                r_user_update;

  logic                w_sel_user;
  logic                w_shift_ir;
  logic                w_shift_dr;
  logic                w_dr_lsb;

  // Two-flop synchronizers; the third TCK flop provides edge detection.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_tck_s <= '0;
      r_tms_s <= '0;
      r_tdi_s <= '0;
    end else begin
      r_tck_s <= {r_tck_s[1:0], TCK};
      r_tms_s <= {r_tms_s[0], TMS};
      r_tdi_s <= {r_tdi_s[0], TDI};
    end
  end

  assign w_tck_r = r_tck_s[1] & ~r_tck_s[2];
  assign w_tck_f = ~r_tck_s[1] & r_tck_s[2];

  jtag_tap_fsm u_fsm (
    .CLK    (CLK),
    .RESETn (RESETn),
    .step   (w_tck_r),
    .TMS    (r_tms_s[1]),
    .state  (w_state)
  );

  assign w_sel_user = (r_ir == OP_USER);
  assign w_shift_ir = (w_state == SHIFT_IR);
  assign w_shift_dr = (w_state == SHIFT_DR);

  // IR: held at the reset instruction in Test-Logic-Reset, loaded on Update-IR.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                              r_ir <= RST_INSTR;
    else if (w_state == TEST_LOGIC_RESET)     r_ir <= RST_INSTR;
    else if (w_tck_f && w_state == UPDATE_IR) r_ir <= r_ir_sr;
  end

  // IR shift register: capture pattern, then shift right with TDI at the MSB.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_ir_sr <= '0;
    else if (w_tck_r) begin
      if (w_state == CAPTURE_IR) r_ir_sr <= IR_CAP;
      else if (w_shift_ir)       r_ir_sr <= {r_tdi_s[1], r_ir_sr[IR_LEN-1:1]};
    end
  end

  // User DR and BYPASS: capture and shift only while selected by the IR.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_user_sr <= '0;
      r_bypass  <= 1'b0;
    end else if (w_tck_r) begin
      if (w_sel_user) begin
        if (w_state == CAPTURE_DR) r_user_sr <= USER_DIN;
        else if (w_shift_dr)       r_user_sr <= {r_tdi_s[1], r_user_sr[USER_LEN-1:1]};
      end
      if (w_state == CAPTURE_DR) r_bypass <= 1'b0;
      else if (w_shift_dr)       r_bypass <= r_tdi_s[1];
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic        w_sel_id;
  logic [31:0] r_id_sr;
  assign w_sel_id = (r_ir == OP_IDCODE);

  // IDCODE DR: loads the fixed ID in Capture-DR and shifts like the others.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_id_sr <= '0;
    else if (w_tck_r && w_sel_id) begin
      if (w_state == CAPTURE_DR) r_id_sr <= IDCODE;
      else if (w_shift_dr)       r_id_sr <= {r_tdi_s[1], r_id_sr[31:1]};
    end
  end
`else
  logic w_unused_id;
  assign w_unused_id = ^{IDCODE, OP_IDCODE};
`endif

  // Serial output of the DR selected by the current instruction.
  always_comb begin
    w_dr_lsb = r_bypass;
    if (w_sel_user) w_dr_lsb = r_user_sr[0];
`ifdef JTAG_TAP_IDCODE_EN
    if (w_sel_id)   w_dr_lsb = r_id_sr[0];
`endif
  end

  // TDO/TDO_OE change on TCK falling so they are stable at the next rising edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_tck_f) begin
      r_tdo    <= w_shift_ir ? r_ir_sr[0] : (w_shift_dr ? w_dr_lsb : 1'b0);
      r_tdo_oe <= w_shift_ir | w_shift_dr;
    end
  end

  // Parallel user output, written with a one-CLK pulse on Update-DR.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_user_dout   <= '0;
      r_user_update <= 1'b0;
    end else begin
      r_user_update <= 1'b0;
      if (w_tck_f && w_state == UPDATE_DR && w_sel_user) begin
        r_user_dout   <= r_user_sr;
        r_user_update <= 1'b1;
      end
    end
  end

  assign TDO         = r_tdo;
  assign TDO_OE      = r_tdo_oe;
  assign USER_DOUT   = r_user_dout;
  assign USER_UPDATE = r_user_update;

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target: directed JTAG scans; expected TDO bits and USER_DOUT
// writes go into queues that independent monitors pop and compare.
module tb_jtag_tap_target;

  localparam int UL = 64;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          TCK = 1'b0;
  logic          TMS = 1'b1;
  logic          TDI = 1'b0;
  logic          TDO;
  logic          TDO_OE;
  logic [UL-1:0] USER_DIN = '0;
  logic [UL-1:0] USER_DOUT;
  logic          USER_UPDATE;

  int n_checks = 0;
  int n_pass   = 0;

  logic          q_tdo[$];
  logic [UL-1:0] q_upd[$];
  logic          m_bit;
  logic [UL-1:0] m_upd;
  logic          m_prev_upd = 1'b0;

  always #5 CLK = ~CLK;

  jtag_tap_target dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .TCK         (TCK),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .TDO_OE      (TDO_OE),
    .USER_DIN    (USER_DIN),
    .USER_DOUT   (USER_DOUT),
    .USER_UPDATE (USER_UPDATE)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // TDO monitor: every TCK rise while TDO_OE is high consumes one expected bit.
  always @(posedge TCK) begin
    if (TDO_OE === 1'b1) begin
      if (q_tdo.size() == 0) check("tdo_oe_unexpected", 64'(TDO_OE), 64'd0);
      else begin
        m_bit = q_tdo.pop_front();
        check("tdo_bit", 64'(TDO), 64'(m_bit));
      end
    end
  end

  // Update monitor: each USER_UPDATE pulse consumes one expected USER_DOUT.
  always @(negedge CLK) begin
    if (USER_UPDATE === 1'b1) begin
      if (m_prev_upd) check("user_update_width", 64'(USER_UPDATE), 64'd0);
      else if (q_upd.size() == 0) check("user_update_unexpected", 64'(USER_UPDATE), 64'd0);
      else begin
        m_upd = q_upd.pop_front();
        check("user_dout", USER_DOUT, m_upd);
      end
    end
    m_prev_upd = (USER_UPDATE === 1'b1);
  end

  // One TCK period: 4 CLK setup, 4 CLK high, 4 CLK low.
  task automatic tck(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    repeat (4) @(negedge CLK);
    TCK = 1'b1;
    repeat (4) @(negedge CLK);
    TCK = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic go_shift_dr();
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
  endtask

  task automatic go_shift_ir();
    tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
  endtask

  // Exit1 -> Update -> Run-Test/Idle.
  task automatic finish_scan();
    tck(1'b1, 1'b0); tck(1'b0, 1'b0);
  endtask

  // Shift n bits LSB-first; optionally leave Shift on the last bit.
  task automatic shift(input int n, input logic [63:0] tdi, input logic [63:0] exp,
                       input logic exit_last);
    for (int i = 0; i < n; i++) begin
      q_tdo.push_back(exp[i]);
      tck(exit_last && (i == n - 1), tdi[i]);
    end
  endtask

  task automatic load_ir(input logic [3:0] op);
    go_shift_ir();
    shift(4, 64'(op), 64'h1, 1'b1);
    finish_scan();
  endtask

  // DR scan under the reset instruction, starting from Run-Test/Idle.
  task automatic scan_reset_dr();
    go_shift_dr();
`ifdef JTAG_TAP_IDCODE_EN
    shift(32, 64'h0, 64'h4BA00477, 1'b1);
`else
    shift(8, 64'hB5, 64'h6A, 1'b1);
`endif
    finish_scan();
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_tdo",         64'(TDO),         64'd0);
    check("rst_tdo_oe",      64'(TDO_OE),      64'd0);
    check("rst_user_dout",   USER_DOUT,        64'd0);
    check("rst_user_update", 64'(USER_UPDATE), 64'd0);
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);

    // Post-reset DR scan under the reset instruction.
    tck(1'b0, 1'b0);
    scan_reset_dr();

    // IR capture pattern, then 1-bit bypass with IR = all-ones.
    load_ir(4'hF);
    go_shift_dr();
    shift(3, 64'b101, 64'b010, 1'b1);
    finish_scan();

    // User DR capture/shift/update.
    load_ir(4'h2);
    USER_DIN = 64'h0123456789ABCDEF;
    go_shift_dr();
    q_upd.push_back(64'hA5A55A5AF00DCAFE);
    shift(64, 64'hA5A55A5AF00DCAFE, 64'h0123456789ABCDEF, 1'b1);
    finish_scan();
    check("user_dout_hold", USER_DOUT, 64'hA5A55A5AF00DCAFE);

    // Five TMS=1 edges from Shift-DR under BYPASS reach Test-Logic-Reset.
    load_ir(4'hF);
    go_shift_dr();
    q_tdo.push_back(1'b0);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b1);
    tck(1'b0, 1'b0);
    scan_reset_dr();

    // Asynchronous reset in the middle of a user shift.
    load_ir(4'h2);
    USER_DIN = 64'h13579BDF2468ACE5;
    go_shift_dr();
    shift(10, 64'h3FF, 64'h0E5, 1'b0);
    check("tdo_before_reset", 64'(TDO), 64'd1);
    RESETn = 1'b0;
    #1;
    check("mid_rst_tdo",         64'(TDO),         64'd0);
    check("mid_rst_tdo_oe",      64'(TDO_OE),      64'd0);
    check("mid_rst_user_dout",   USER_DOUT,        64'd0);
    check("mid_rst_user_update", 64'(USER_UPDATE), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);
    tck(1'b0, 1'b0);
    scan_reset_dr();

    // IR = 1: IDCODE when present, otherwise 1-bit bypass.
    load_ir(4'h1);
    go_shift_dr();
`ifdef JTAG_TAP_IDCODE_EN
    shift(32, 64'h0, 64'h4BA00477, 1'b1);
`else
    shift(4, 64'b1011, 64'b0110, 1'b1);
`endif
    finish_scan();

    repeat (10) @(negedge CLK);
    check("tdo_queue_drained", 64'(q_tdo.size()), 64'd0);
    check("upd_queue_drained", 64'(q_upd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
